// File: rtl/sw_cond_pkg.sv
// Shared constants for the slide-switch conditioner.
// Holds the export word field positions, the default debounce length, the channel limit,
// and a helper that sizes the stability counter.
package sw_cond_pkg;

  localparam int EXP_DB_LSB              = 0;
  localparam int EXP_EVT_LSB             = 16;
  localparam int EXPORT_W                = 32;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int MAX_WIDTH               = 16;

  // Stability counter width. The counter only has to reach n-1, so $clog2(n) bits suffice.
  // The result is held at 1 or more so that a degenerate n still gives a legal vector.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// Single-channel debouncer: two-flop synchronizer plus a stability counter.
// Ports: clk/rst (async, active-high), sw_in raw line, sw_db debounced level,
//        rise/fall one-cycle pulses on an accepted change.
module debounce_cell
  import sw_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic sw_db,
  output logic rise,
  output logic fall
);

  localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      sw_db <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == sw_db) begin
        // The line agrees with the accepted level, so any partial count was a glitch.
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // This is the DEBOUNCE_CYCLES-th consecutive disagreeing cycle, so take the new level.
        sw_db <= sync2;
        cnt   <= '0;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_conditioner.sv
// Conditions the board slide switches for the SoC buttons PIO: per-channel debounce,
// rise/fall pulses, and sticky "rose since last clear" flags packed into a 32-bit word.
// Ports: clk/rst (async, active-high), sw_in raw lines, evt_clr sticky clear pulse,
//        sw_db/rise/fall/evt_sticky per channel, and export_word as the packed PIO view.
module sw_conditioner
  import sw_cond_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    sw_in,
  input  logic                evt_clr,
  output logic [WIDTH-1:0]    sw_db,
  output logic [WIDTH-1:0]    rise,
  output logic [WIDTH-1:0]    fall,
  output logic [WIDTH-1:0]    evt_sticky,
  output logic [EXPORT_W-1:0] export_word
);

  // Each field of the export word is 16 bits wide, so wider configurations cannot be packed.
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("sw_conditioner: WIDTH must be in 1..16");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("sw_conditioner: DEBOUNCE_CYCLES must be at least 2");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .sw_in (sw_in[i]),
      .sw_db (sw_db[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // A rise wins over a clear in the same cycle, so a press that lands on the clear is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_sticky <= '0;
    end else begin
      evt_sticky <= (evt_sticky & ~{WIDTH{evt_clr}}) | rise;
    end
  end

  always_comb begin
    export_word                         = '0;
    export_word[EXP_DB_LSB  +: WIDTH]   = sw_db;
    export_word[EXP_EVT_LSB +: WIDTH]   = evt_sticky;
  end

endmodule

// File: tb/tb_sw_conditioner.sv
// Self-checking bench for sw_conditioner with WIDTH=8 and DEBOUNCE_CYCLES=4.
// A reference model accepts a new level once the last D synchronized samples all differ from it.
module tb_sw_conditioner;

  localparam int W = 8;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  sw_in;
  logic          evt_clr;
  logic [W-1:0]  sw_db, rise, fall, evt_sticky;
  logic [31:0]   export_word;

  sw_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_in       (sw_in),
    .evt_clr     (evt_clr),
    .sw_db       (sw_db),
    .rise        (rise),
    .fall        (fall),
    .evt_sticky  (evt_sticky),
    .export_word (export_word)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model. m_hist holds the raw sw_in value sampled at each of the last D+2 edges.
  // The oldest D entries are the synchronized samples that the stability window sees at the newest edge.
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_db, m_rise, m_fall, m_sticky;

  task automatic model_reset();
    m_hist.delete();
    for (int k = 0; k < D + 2; k++) m_hist.push_back('0);
    m_db = '0; m_rise = '0; m_fall = '0; m_sticky = '0;
  endtask

  task automatic model_step(input logic [W-1:0] s, input logic c);
    logic [W-1:0] nd, nr, nf, h;
    bit           all_diff;
    m_sticky = (m_sticky & ~{W{c}}) | m_rise;
    m_hist.push_back(s);
    void'(m_hist.pop_front());
    nd = m_db; nr = '0; nf = '0;
    for (int i = 0; i < W; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) begin
        h = m_hist[j];
        if (h[i] == m_db[i]) all_diff = 1'b0;
      end
      if (all_diff) begin
        nd[i] = ~m_db[i];
        if (nd[i]) nr[i] = 1'b1;
        else       nf[i] = 1'b1;
      end
    end
    m_db = nd; m_rise = nr; m_fall = nf;
  endtask

  task automatic compare_all();
    chk("sw_db",  32'(sw_db),      32'(m_db));
    chk("rise",   32'(rise),       32'(m_rise));
    chk("fall",   32'(fall),       32'(m_fall));
    chk("sticky", 32'(evt_sticky), 32'(m_sticky));
    chk("export", export_word,     {8'h00, m_sticky, 8'h00, m_db});
  endtask

  // Runs one clock: the model steps on the inputs held across the edge,
  // and the outputs are compared at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step(sw_in, evt_clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  logic [W-1:0] cur;
  int           dur;

  initial begin
    rst = 1'b1; sw_in = '0; evt_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_sw_db",  32'(sw_db), 32'h0);
    chk("rst_rise",   32'(rise),  32'h0);
    chk("rst_export", export_word, 32'h0);
    rst = 1'b0;

    // Idle inputs
    cycles(20);
    chk("idle_export", export_word, 32'h0);

    // 0x00 -> 0x05 is accepted at edge 6
    sw_in = 8'h05;
    cycles(5);
    chk("rise_pre_db", 32'(sw_db), 32'h0);
    cycle();
    chk("rise_db",   32'(sw_db), 32'h05);
    chk("rise_puls", 32'(rise),  32'h05);
    cycle();
    chk("rise_one",  32'(rise),  32'h0);
    chk("rise_stk",  32'(evt_sticky), 32'h05);
    chk("rise_exp",  export_word, 32'h0005_0005);

    // A 3-cycle glitch on bit 3 is rejected
    sw_in = 8'h0D;
    cycles(3);
    sw_in = 8'h05;
    cycles(10);
    chk("glitch_db",  32'(sw_db),      32'h05);
    chk("glitch_stk", 32'(evt_sticky), 32'h05);

    // Fall leaves the sticky flags untouched
    sw_in = 8'h00;
    cycles(5);
    cycle();
    chk("fall_puls", 32'(fall),       32'h05);
    chk("fall_db",   32'(sw_db),      32'h00);
    chk("fall_stk",  32'(evt_sticky), 32'h05);

    // A clear that coincides with rise[1]: the set wins and the other flags clear
    sw_in = 8'h02;
    cycles(6);
    chk("clr_rise", 32'(rise), 32'h02);
    evt_clr = 1'b1;
    cycle();
    evt_clr = 1'b0;
    chk("clr_stk", 32'(evt_sticky), 32'h02);

    // Reset asserted two cycles into a pending rise on bit 7
    sw_in = 8'h82;
    cycles(2);
    rst = 1'b1;
    #1;
    chk("mid_rst_db",     32'(sw_db),      32'h0);
    chk("mid_rst_stk",    32'(evt_sticky), 32'h0);
    chk("mid_rst_export", export_word,     32'h0);
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("in_rst_rise", 32'(rise), 32'h0);
    end
    rst = 1'b0;
    cycles(5);
    chk("post_rst_pre", 32'(rise), 32'h0);
    cycle();
    chk("post_rst_rise", 32'(rise), 32'h82);

    // Randomized segments with random sticky clears
    cur = sw_in;
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 2) == 0) cur = 8'($urandom);
      else                           cur = cur ^ (8'h01 << $urandom_range(0, 7));
      sw_in = cur;
      dur = $urandom_range(1, 9);
      for (int k = 0; k < dur; k++) begin
        evt_clr = ($urandom_range(0, 5) == 0);
        cycle();
      end
      evt_clr = 1'b0;
    end
    cycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
